// File: rtl/muldiv_pkg.sv
// Shared types and operand-signedness helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic a_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide trial subtract.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  muldiv_op_e                  i_op,
    input  logic [2*DATA_WIDTH-1:0]     i_acc,
    input  logic [DATA_WIDTH-1:0]       i_x,
    input  logic [DATA_WIDTH-1:0]       i_y,
    output logic [2*DATA_WIDTH-1:0]     o_acc,
    output logic [DATA_WIDTH-1:0]       o_x
);
    localparam int W = DATA_WIDTH;

    logic [W-1:0] w_addend;
    logic [W:0]   w_sum;
    logic [W:0]   w_rem_sh;
    logic [W+1:0] w_diff;

    // Multiply: acc = {partial product, multiplier tail}; divide: acc high half is the remainder
    // and x shifts dividend bits out of its MSB while quotient bits enter at its LSB.
    always_comb begin
        w_addend = i_x[0] ? i_y : '0;
        w_sum    = {1'b0, i_acc[2*W-1:W]} + {1'b0, w_addend};
        w_rem_sh = {i_acc[2*W-1:W], i_x[W-1]};
        w_diff   = {1'b0, w_rem_sh} - {2'b00, i_y};
        if (op_is_div(i_op)) begin
            o_acc = {(w_diff[W+1] ? w_rem_sh[W-1:0] : w_diff[W-1:0]), i_acc[W-1:0]};
            o_x   = {i_x[W-2:0], ~w_diff[W+1]};
        end else begin
            o_acc = {w_sum, i_acc[W-1:1]};
            o_x   = {1'b0, i_x[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: fixed DATA_WIDTH+3 cycle latency from start to done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    muldiv_state_e   r_state, w_next;
    muldiv_op_e      r_op;
    logic [W-1:0]    r_a, r_b, r_x, r_y, r_result;
    logic [2*W-1:0]  r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic            r_neg;
    logic [2*W-1:0]  w_acc_nxt;
    logic [W-1:0]    w_x_nxt;
    logic            w_sa, w_sb, w_accept;

    function automatic logic [W-1:0] fix_result(
        input muldiv_op_e     f_op,
        input logic           f_neg,
        input logic           f_bzero,
        input logic [2*W-1:0] f_acc,
        input logic [W-1:0]   f_x,
        input logic [W-1:0]   f_a
    );
        logic [2*W-1:0] prod;
        logic [W-1:0]   quo, rem;
        prod = f_neg ? -f_acc : f_acc;
        quo  = f_neg ? -f_x : f_x;
        rem  = f_neg ? -f_acc[2*W-1:W] : f_acc[2*W-1:W];
        // Divide-by-zero results bypass the sign fix entirely.
        case (f_op)
            OP_MUL:                       return prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*W-1:W];
            OP_DIV, OP_DIVU:              return f_bzero ? '1 : quo;
            default:                      return f_bzero ? f_a : rem;
        endcase
    endfunction

    assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy     = (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign w_accept = start && ready && !flush;
    assign w_sa     = a_signed(r_op) && r_a[W-1];
    assign w_sb     = b_signed(r_op) && r_b[W-1];

    muldiv_step #(.DATA_WIDTH(W)) u_step (
        .i_op  (r_op),
        .i_acc (r_acc),
        .i_x   (r_x),
        .i_y   (r_y),
        .o_acc (w_acc_nxt),
        .o_x   (w_x_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_PREP;
                S_PREP:  w_next = S_CALC;
                S_CALC:  if (r_cnt == LAST) w_next = S_FIX;
                S_FIX:   w_next = S_DONE;
                S_DONE:  w_next = start ? S_PREP : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op <= muldiv_op_e'(op);
                r_a  <= a;
                r_b  <= b;
            end
            case (r_state)
                S_PREP: begin
                    r_x   <= w_sa ? -r_a : r_a;
                    r_y   <= w_sb ? -r_b : r_b;
                    // Remainder takes the dividend's sign; everything else takes sa^sb.
                    r_neg <= (op_is_div(r_op) && r_op[1]) ? w_sa : (w_sa ^ w_sb);
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_x   <= w_x_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!flush) r_result <= fix_result(r_op, r_neg, (r_b == '0), r_acc, r_x, r_a);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency, flush, reset and back-to-back.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         ready, busy, done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] res;
        int           at;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pops one expectation (value and arrival cycle).
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 (result %h) expected done=0", result);
            end else begin
                m_e = sb_q.pop_front();
                chk({m_e.name, "_result"}, result, m_e.res);
                chk({m_e.name, "_cycle"}, W'(cyc), W'(m_e.at));
            end
        end
    end

    // Called on a negedge; returns on the negedge of the cycle after start was high.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] e, input string nm, input bit push);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got ready=%b expected 1", nm, ready);
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sb_q.push_back('{res: e, at: cyc + 35, name: nm});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got pending=%0d expected 0", nm, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] e, input string nm);
        issue(o, x, y, e, nm, 1'b1);
        drain(nm);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready",  W'(ready), 32'd1);
        chk("reset_busy",   W'(busy),  32'd0);
        chk("reset_done",   W'(done),  32'd0);
        chk("reset_result", result,    32'd0);
        reset = 1'b0;
        @(negedge clk);

        // busy profile across one full operation
        issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "MUL_7_m3", 1'b1);
        for (int i = 1; i <= 35; i++) begin
            chk($sformatf("busy_cycle%0d", i), W'(busy), W'(i <= 34));
            if (i < 35) @(negedge clk);
        end
        drain("MUL_7_m3");

        run(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, "MULH_min_min");
        run(OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, "MULHU_min_min");
        run(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "MULHSU_m1_2");
        run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU_max_max");
        run(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "MUL_max_max");
        run(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "MULH_m1_m1");
        run(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "DIV_m7_2");
        run(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "REM_m7_2");
        run(OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, "DIV_7_m2");
        run(OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, "REM_7_m2");
        run(OP_DIVU,   32'd100,      32'd7,        32'd14,       "DIVU_100_7");
        run(OP_REMU,   32'd100,      32'd7,        32'd2,        "REMU_100_7");
        run(OP_DIV,    32'h12345678, 32'd0,        32'hFFFFFFFF, "DIV_by0");
        run(OP_DIVU,   32'h12345678, 32'd0,        32'hFFFFFFFF, "DIVU_by0");
        run(OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "REM_m7_by0");
        run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV_ovf");
        run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "REM_ovf");
        run(OP_REM,    32'h12345678, 32'd0,        32'h12345678, "REM_by0");
        run(OP_REMU,   32'h12345678, 32'd0,        32'h12345678, "REMU_by0");

        // flush at cycle 10, with a competing start in the same cycle
        issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, "flushed", 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = OP_MUL;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk("flush_ready",  W'(ready), 32'd1);
        chk("flush_busy",   W'(busy),  32'd0);
        chk("flush_result", result,    32'h12345678);
        @(negedge clk);
        chk("flush_start_dropped", W'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_result_held", result, 32'h12345678);

        // back-to-back: start presented during DONE
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, "b2b_first", 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done_seen", W'(done), 32'd1);
        start = 1'b1;
        op    = OP_REMU;
        a     = 32'd100;
        b     = 32'd7;
        sb_q.push_back('{res: 32'd2, at: cyc + 35, name: "b2b_second"});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_after_accept", W'(busy), 32'd1);
        drain("b2b_second");

        // reset at cycle 20 of an operation
        issue(OP_MUL, 32'd3, 32'd5, 32'd15, "reset_mid", 1'b0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_ready",  W'(ready), 32'd1);
        chk("midreset_busy",   W'(busy),  32'd0);
        chk("midreset_done",   W'(done),  32'd0);
        chk("midreset_result", result,    32'd0);
        reset = 1'b0;
        repeat (45) @(negedge clk);
        chk("postreset_ready",  W'(ready), 32'd1);
        chk("postreset_result", result,    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M execute unit that sits beside the ALU in the EX stage. It is launched by a one-cycle `start` strobe carrying the M-extension Funct3 and both operands. It runs a shift-add multiply or a restoring divide over `DATA_WIDTH` iterations, and holds the pipeline via `busy` until it pulses `done` with the result. The decoder routes Funct7 = 0000001 R-type instructions here instead of to the ALU.

## Interface
- `DATA_WIDTH`, 32, operand and result width; iteration count equals `DATA_WIDTH`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch request; sampled only when `ready`=1.
- `op`  in  3  Funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  DATA_WIDTH  rs1 value; sampled with `start`.
- `b`  in  DATA_WIDTH  rs2 value; sampled with `start`.
- `flush`  in  1  abort; the in-flight operation is discarded.
- `ready`  out  1  high in IDLE and DONE; `start` is accepted only when high.
- `busy`  out  1  high in PREP, CALC and FIX; the hazard unit stalls IF/ID/EX on it.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  DATA_WIDTH  final value; holds until the next `done`.

## Operation
- States:
  - IDLE: on `start`, go to PREP.
  - PREP: go to CALC.
  - CALC: stay for `DATA_WIDTH` cycles, then go to FIX.
  - FIX: go to DONE.
  - DONE: go to PREP on `start`, otherwise to IDLE.
- Launch: `op`, `a` and `b` are latched when `start` is accepted. The unit never reads them again.
- PREP:
  - Take absolute values of the signed operands. Signedness is per `op`: MULH signs a and b; MULHSU signs a only; DIV and REM sign both; the rest are unsigned.
  - Record the result sign. For MUL-type it is sa^sb. For DIV it is sa^sb. For REM it is sa.
  - Clear the 2×`DATA_WIDTH` accumulator and the counter.
- CALC, multiply: one shift-add step per cycle over a 2×`DATA_WIDTH` product register.
- CALC, divide: one restoring step per cycle. Shift the remainder left 1, subtract the divisor, and keep the result if it is non-negative. Set the quotient bit.
- FIX:
  - Negate the magnitude if the recorded sign is 1.
  - Select the output: MUL gives the low half; MULH, MULHSU and MULHU give the high half; DIV and DIVU give the quotient; REM and REMU give the remainder.
  - Register the selection into `result`.
- Divide by zero (`b`=0): the result is quotient = all ones and remainder = `a`. This overrides the sign fix. Latency is unchanged.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): the result is quotient 0x80000000 and remainder 0. The algorithm produces this naturally; no special case is added.
- `flush` in any state:
  - Next state is IDLE; `done` is not asserted.
  - `result` keeps its previous value.
  - `flush` and `start` in the same cycle: `flush` wins and `start` is dropped.
- `start` while `ready`=0 is ignored. The upstream stall guarantees it does not happen.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `result`=0. The counter and accumulators are cleared.
- `start` accepted at edge k:
  - PREP during cycle k+1.
  - CALC during cycles k+2 … k+`DATA_WIDTH`+1.
  - FIX during cycle k+`DATA_WIDTH`+2.
  - `done`=1 during cycle k+`DATA_WIDTH`+3 (cycle 35 for width 32).
- Latency is fixed and independent of `op` and operand values.
- `busy` rises in the cycle after acceptance and falls in the cycle `done` rises.
- Back-to-back: a `start` sampled in DONE enters PREP at the next edge. Sustained throughput is one result per `DATA_WIDTH`+3 cycles.
- `reset` mid-operation returns all outputs to their reset values at the next edge. `reset` has priority over `flush` and `start`.
- All outputs are driven from registers or directly from state decode. There is no combinational path from the inputs to the outputs.

## Structure
- Package `muldiv_pkg`:
  - Enum `muldiv_op_e`, with the eight Funct3 encodings above.
  - Enum `muldiv_state_e`: IDLE, PREP, CALC, FIX, DONE.
  - Helper functions `op_is_div`, `a_signed` and `b_signed`.
- One module. The counter is a `$clog2(DATA_WIDTH)+1`-bit register.
- The single natural sub-module is `muldiv_step`: a combinational one-iteration datapath, multiply add-shift or divide trial-subtract, chosen by `op_is_div`. The FSM owns all registers.

## Test plan
- MUL a=7, b=−3 (0xFFFFFFFD) → `done` at cycle 35 after `start`, `result`=0xFFFFFFEB; `busy` high for exactly cycles 1–34.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHU with the same operands → 0x40000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=−7, b=2 → 0xFFFFFFFD. REM a=−7, b=2 → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU a=100, b=7 → 2.
- DIV/DIVU with b=0, a=0x12345678 → 0xFFFFFFFF. REM/REMU with b=0 → 0x12345678. DIV 0x80000000 by −1 → 0x80000000. REM 0x80000000 by −1 → 0.
- `flush` at cycle 10 of an operation → IDLE next cycle, no `done`, `result` unchanged. A `start` in the same cycle as `flush` is not accepted.
- `start` held during DONE → the second operation's `done` arrives 35 cycles after the first. `reset` asserted at cycle 20 → all outputs at reset values next cycle, and no `done` follows.
